mem_access_ctrl: RTL and testbench

- M-stage data-memory access controller for the P7 MIPS pipeline. It sits directly upstream of the load-extension unit.
- Takes one load/store request per instruction and checks alignment and address range, raising AdEL/AdES.
- Runs a req/ack transaction on the data bus (DM or bridge), stalling the pipeline until the bus acknowledges.
- Registers the raw read word, byte offset and load type for the load-extension unit.

---
 rtl/mem_access_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Brief    : M-stage data-memory access controller: AdEL/AdES checks, req/ack
//            bus transaction with pipeline stall, raw load word registration.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter logic [31:0] DM_TOP    = 32'h0000_2FFF,
    parameter logic [31:0] PERIPH_LO = 32'h0000_7F00,
    parameter logic [31:0] PERIPH_HI = 32'h0000_7F1B
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_flush,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        stall,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic [1:0]  ld_byte_addr,
    output logic [2:0]  ld_type
);

    localparam logic [2:0] c_TY_BS = 3'b001;
    localparam logic [2:0] c_TY_BU = 3'b010;
    localparam logic [2:0] c_TY_HS = 3'b011;
    localparam logic [2:0] c_TY_HU = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic        bus_req_q;
    logic        bus_we_q;
    logic [31:0] bus_addr_q;
    logic [3:0]  bus_be_q;
    logic [31:0] bus_wdata_q;
    logic [1:0]  off_q;
    logic [2:0]  type_q;
    logic        drop_q;
    logic        ld_valid_q;
    logic [31:0] ld_data_q;
    logic [1:0]  ld_byte_addr_q;
    logic [2:0]  ld_type_q;

    logic        w_is_byte;
    logic        w_is_half;
    logic        w_is_word;
    logic        w_in_dm;
    logic        w_in_periph;
    logic        w_misalign;
    logic        w_range_fault;
    logic        w_periph_fault;
    logic        w_fault;
    logic        w_check;
    logic        w_accept;
    logic        w_drop;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    // Unknown type codes fall back to the word rules (strictest alignment).
    always_comb begin
        w_is_byte = (req_type == c_TY_BS) || (req_type == c_TY_BU);
        w_is_half = (req_type == c_TY_HS) || (req_type == c_TY_HU);
        w_is_word = !w_is_byte && !w_is_half;
    end

    assign w_in_dm        = (req_addr <= DM_TOP);
    assign w_in_periph    = (req_addr >= PERIPH_LO) && (req_addr <= PERIPH_HI);
    assign w_misalign     = (w_is_word && (req_addr[1:0] != 2'b00)) ||
                            (w_is_half && req_addr[0]);
    assign w_range_fault  = !w_in_dm && !w_in_periph;
    // Peripherals are word-only, and the timer COUNT register is read-only.
    assign w_periph_fault = w_in_periph &&
                            (!w_is_word || (req_we && (req_addr[3:0] == 4'h8)));
    assign w_fault        = w_misalign || w_range_fault || w_periph_fault;

    assign w_check  = reset_n && (state_q == ST_IDLE) && req_valid && !req_flush;
    assign w_accept = w_check && !w_fault;
    assign w_drop   = drop_q || req_flush;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = req_wdata;
        if (w_is_half) begin
            w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{req_wdata[15:0]}};
        end else if (w_is_byte) begin
            w_be    = 4'b0001 << req_addr[1:0];
            w_wdata = {4{req_wdata[7:0]}};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            bus_req_q      <= 1'b0;
            bus_we_q       <= 1'b0;
            bus_addr_q     <= 32'h0;
            bus_be_q       <= 4'h0;
            bus_wdata_q    <= 32'h0;
            off_q          <= 2'b00;
            type_q         <= 3'b000;
            drop_q         <= 1'b0;
            ld_valid_q     <= 1'b0;
            ld_data_q      <= 32'h0;
            ld_byte_addr_q <= 2'b00;
            ld_type_q      <= 3'b000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= req_we;
                        bus_addr_q  <= {req_addr[31:2], 2'b00};
                        bus_be_q    <= w_be;
                        bus_wdata_q <= w_wdata;
                        off_q       <= req_addr[1:0];
                        type_q      <= req_type;
                        drop_q      <= 1'b0;
                        state_q     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (req_flush) begin
                        drop_q <= 1'b1;
                    end
                    if (bus_ack) begin
                        bus_req_q <= 1'b0;
                        drop_q    <= 1'b0;
                        state_q   <= ST_DONE;
                        // A flushed load still completes on the bus but its
                        // data never reaches the load-extension unit.
                        if (!bus_we_q && !w_drop) begin
                            ld_valid_q     <= 1'b1;
                            ld_data_q      <= bus_rdata;
                            ld_byte_addr_q <= off_q;
                            ld_type_q      <= type_q;
                        end
                    end
                end
                ST_DONE: begin
                    ld_valid_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus_req      = bus_req_q;
    assign bus_we       = bus_we_q;
    assign bus_addr     = bus_addr_q;
    assign bus_be       = bus_be_q;
    assign bus_wdata    = bus_wdata_q;
    assign stall        = reset_n && ((state_q == ST_BUSY) || w_accept);
    assign exc_adel     = w_check && w_fault && !req_we;
    assign exc_ades     = w_check && w_fault && req_we;
    assign ld_valid     = ld_valid_q;
    assign ld_data      = ld_data_q;
    assign ld_byte_addr = ld_byte_addr_q;
    assign ld_type      = ld_type_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Brief    : Self-checking bench for mem_access_ctrl: directed scenarios plus
//            randomized traffic against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    localparam logic [31:0] c_DM_TOP = 32'h0000_2FFF;
    localparam logic [31:0] c_P_LO   = 32'h0000_7F00;
    localparam logic [31:0] c_P_HI   = 32'h0000_7F1B;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_type = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        req_flush = 1'b0;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        stall;
    logic        exc_adel;
    logic        exc_ades;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic [1:0]  ld_byte_addr;
    logic [2:0]  ld_type;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_type     (req_type),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_flush    (req_flush),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_be       (bus_be),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata),
        .stall        (stall),
        .exc_adel     (exc_adel),
        .exc_ades     (exc_ades),
        .ld_valid     (ld_valid),
        .ld_data      (ld_data),
        .ld_byte_addr (ld_byte_addr),
        .ld_type      (ld_type)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    function automatic int acc_size(input logic [2:0] t);
        case (t)
            3'd1, 3'd2: return 1;
            3'd3, 3'd4: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic bit is_fault(input logic we, input logic [2:0] t, input logic [31:0] a);
        int sz = acc_size(t);
        bit in_dm = (a <= c_DM_TOP);
        bit in_p  = (a >= c_P_LO) && (a <= c_P_HI);
        if ((a % sz) != 0) return 1'b1;
        if (!in_dm && !in_p) return 1'b1;
        if (in_p && sz != 4) return 1'b1;
        if (in_p && we && ((a % 16) == 8)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [31:0] a, input logic [2:0] t);
        int m;
        m = ((1 << acc_size(t)) - 1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] d, input logic [2:0] t);
        case (acc_size(t))
            1:       return {4{d[7:0]}};
            2:       return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    bit          m_pend = 1'b0;
    bit          m_done = 1'b0;
    bit          m_drop = 1'b0;
    logic [31:0] m_addr = 32'h0;
    logic [31:0] m_wdata = 32'h0;
    logic        m_we = 1'b0;
    logic [2:0]  m_type = 3'b000;
    logic        m_ldv = 1'b0;
    logic [31:0] m_ldd = 32'h0;
    logic [1:0]  m_ldo = 2'b00;
    logic [2:0]  m_ldt = 3'b000;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pend = 1'b0; m_done = 1'b0; m_drop = 1'b0;
            m_ldv = 1'b0; m_ldd = 32'h0; m_ldo = 2'b00; m_ldt = 3'b000;
        end else if (m_done) begin
            m_done = 1'b0;
            m_ldv  = 1'b0;
        end else if (m_pend) begin
            if (req_flush) m_drop = 1'b1;
            if (bus_ack) begin
                m_pend = 1'b0;
                m_done = 1'b1;
                if (!m_we && !m_drop) begin
                    m_ldv = 1'b1;
                    m_ldd = bus_rdata;
                    m_ldo = m_addr[1:0];
                    m_ldt = m_type;
                end
                m_drop = 1'b0;
            end
        end else if (req_valid && !req_flush && !is_fault(req_we, req_type, req_addr)) begin
            m_pend  = 1'b1;
            m_addr  = req_addr;
            m_we    = req_we;
            m_type  = req_type;
            m_wdata = req_wdata;
            m_drop  = 1'b0;
        end
    end

    logic e_chk;
    logic e_f;

    always @(negedge clk) begin
        e_chk = reset_n && !m_pend && !m_done && req_valid && !req_flush;
        e_f   = is_fault(req_we, req_type, req_addr);
        chk1("bus_req", bus_req, m_pend);
        chk1("stall", stall, m_pend || (e_chk && !e_f));
        chk1("exc_adel", exc_adel, e_chk && e_f && !req_we);
        chk1("exc_ades", exc_ades, e_chk && e_f && req_we);
        if (m_pend) begin
            chk1("bus_we", bus_we, m_we);
            chkw("bus_addr", bus_addr, m_addr - (m_addr % 4));
            chkw("bus_be", 32'(bus_be), 32'(exp_be(m_addr, m_type)));
            if (m_we) chkw("bus_wdata", bus_wdata, exp_wdata(m_wdata, m_type));
        end
        chk1("ld_valid", ld_valid, m_ldv);
        chkw("ld_data", ld_data, m_ldd);
        chkw("ld_byte_addr", 32'(ld_byte_addr), 32'(m_ldo));
        chkw("ld_type", 32'(ld_type), 32'(m_ldt));
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        req_valid = 1'b0; req_we = 1'b0; req_type = 3'b000; req_addr = 32'h0;
        req_wdata = 32'h0; req_flush = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
    endtask

    task automatic set_req(input logic we, input logic [2:0] t, input logic [31:0] a,
                           input logic [31:0] d);
        req_valid = 1'b1; req_we = we; req_type = t; req_addr = a; req_wdata = d;
        req_flush = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 4))
            0:       return 32'($urandom_range(0, 32'h2FFF));
            1:       return 32'h2FF8 + 32'($urandom_range(0, 15));
            2:       return 32'h7EF8 + 32'($urandom_range(0, 47));
            3:       return $urandom;
            default: return 32'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        idle_in();
        #1 reset_n = 1'b0;
        step(); step();
        chk1("rst_bus_req", bus_req, 1'b0);
        chk1("rst_stall", stall, 1'b0);
        chk1("rst_ld_valid", ld_valid, 1'b0);
        chkw("rst_ld_data", ld_data, 32'h0);
        reset_n = 1'b1;

        // Load byte unsigned with one wait state.
        step();
        set_req(1'b0, 3'b010, 32'h0000_0101, 32'h0);
        @(negedge clk);
        chk1("t1_stall_accept", stall, 1'b1);
        chk1("t1_no_req_yet", bus_req, 1'b0);
        step();
        @(negedge clk);
        chk1("t1_bus_req", bus_req, 1'b1);
        chkw("t1_bus_addr", bus_addr, 32'h0000_0100);
        chkw("t1_bus_be", 32'(bus_be), 32'h2);
        chk1("t1_bus_we", bus_we, 1'b0);
        step();
        bus_ack = 1'b1; bus_rdata = 32'h0123_FDEC;
        @(negedge clk);
        chk1("t1_stall_wait", stall, 1'b1);
        step();
        idle_in();
        @(negedge clk);
        chk1("t1_stall_done", stall, 1'b0);
        chk1("t1_ld_valid", ld_valid, 1'b1);
        chkw("t1_ld_data", ld_data, 32'h0123_FDEC);
        chkw("t1_ld_off", 32'(ld_byte_addr), 32'h1);
        chkw("t1_ld_type", 32'(ld_type), 32'h2);
        step();
        @(negedge clk);
        chk1("t1_ld_valid_pulse", ld_valid, 1'b0);

        // Store half.
        step();
        set_req(1'b1, 3'b011, 32'h0000_0202, 32'h0000_ABCD);
        step();
        @(negedge clk);
        chk1("t2_bus_we", bus_we, 1'b1);
        chkw("t2_bus_be", 32'(bus_be), 32'hC);
        chkw("t2_bus_wdata", bus_wdata, 32'hABCD_ABCD);
        chkw("t2_bus_addr", bus_addr, 32'h0000_0200);
        step();
        bus_ack = 1'b1;
        step();
        idle_in();
        @(negedge clk);
        chk1("t2_no_ld_valid", ld_valid, 1'b0);
        chkw("t2_ld_data_hold", ld_data, 32'h0123_FDEC);
        step();

        // Misaligned word load, out-of-range byte store.
        step();
        set_req(1'b0, 3'b000, 32'h0000_0006, 32'h0);
        @(negedge clk);
        chk1("t3_adel", exc_adel, 1'b1);
        chk1("t3_adel_stall", stall, 1'b0);
        step();
        set_req(1'b1, 3'b001, 32'h0000_3000, 32'h5A);
        @(negedge clk);
        chk1("t3_no_req", bus_req, 1'b0);
        chk1("t3_ades", exc_ades, 1'b1);

        // Peripheral rules.
        step();
        set_req(1'b1, 3'b000, 32'h0000_7F08, 32'h1);
        @(negedge clk);
        chk1("t4_count_ades", exc_ades, 1'b1);
        step();
        set_req(1'b0, 3'b011, 32'h0000_7F04, 32'h0);
        @(negedge clk);
        chk1("t4_half_adel", exc_adel, 1'b1);
        step();
        set_req(1'b0, 3'b000, 32'h0000_7F04, 32'h0);
        @(negedge clk);
        chk1("t4_word_stall", stall, 1'b1);
        chk1("t4_word_no_adel", exc_adel, 1'b0);
        step();
        @(negedge clk);
        chkw("t4_bus_addr", bus_addr, 32'h0000_7F04);
        step();
        bus_ack = 1'b1; bus_rdata = 32'h55AA_1234;
        step();
        idle_in();
        @(negedge clk);
        chkw("t4_ld_data", ld_data, 32'h55AA_1234);
        step();

        // Flush while BUSY on a load.
        step();
        set_req(1'b0, 3'b000, 32'h0000_0010, 32'h0);
        step();
        req_flush = 1'b1;
        step();
        req_flush = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        step();
        idle_in();
        @(negedge clk);
        chk1("t5_no_ld_valid", ld_valid, 1'b0);
        chkw("t5_ld_data_hold", ld_data, 32'h55AA_1234);
        step();
        set_req(1'b0, 3'b000, 32'h0000_0014, 32'h0);
        @(negedge clk);
        chk1("t5_back_idle", stall, 1'b1);

        // Async reset mid-transaction, then a fresh load.
        step();
        @(negedge clk);
        chk1("t6_busy", bus_req, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk1("t6_rst_bus_req", bus_req, 1'b0);
        chk1("t6_rst_stall", stall, 1'b0);
        chkw("t6_rst_ld_data", ld_data, 32'h0);
        chkw("t6_rst_ld_type", 32'(ld_type), 32'h0);
        idle_in();
        step();
        reset_n = 1'b1;
        set_req(1'b0, 3'b100, 32'h0000_0046, 32'h0);
        step();
        bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
        step();
        idle_in();
        @(negedge clk);
        chk1("t6_ld_valid", ld_valid, 1'b1);
        chkw("t6_ld_data", ld_data, 32'hCAFE_F00D);
        chkw("t6_ld_off", 32'(ld_byte_addr), 32'h2);
        chkw("t6_ld_type", 32'(ld_type), 32'h4);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            step();
            req_valid = ($urandom_range(0, 3) != 0);
            req_we    = 1'($urandom_range(0, 1));
            if (req_we) begin
                case ($urandom_range(0, 2))
                    0:       req_type = 3'b000;
                    1:       req_type = 3'b001;
                    default: req_type = 3'b011;
                endcase
            end else begin
                req_type = 3'($urandom_range(0, 4));
            end
            req_addr  = rand_addr();
            req_wdata = $urandom;
            req_flush = ($urandom_range(0, 9) == 0);
            bus_ack   = ($urandom_range(0, 2) == 0);
            bus_rdata = $urandom;
        end

        idle_in();
        bus_ack = 1'b1;
        repeat (4) step();
        idle_in();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
